weight_fetch_responder: RTL and testbench
=========================================

Name: weight_fetch_responder

Overview:
- Responder side of the accelerator's SRAM_read_req / DVAL weight handshake.
- Captures the same 5-word databus configuration sequence as the accelerator FSM, keeping only the weight base, input count and output count.
- On each read request, fetches BURST_LEN consecutive weight words from the memory controller into a parallel buffer (SDRAM_FIFO), then pulses DVAL.
- Sits between the memory controller and the accelerator FSM.

Parameters:
DATA_W, 16, weight word width
ADDR_W, 16, memory word-address width
BURST_LEN, 16, words per burst; must equal the accelerator PE count (power of two)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
Enable  in  1  start of a layer; sampled only in IDLE
databus  in  16  configuration word
busrdwr  in  1  databus beat valid
SRAM_read_req  in  1  one-cycle pulse requesting the next burst
mem_rd_req  out  1  read request to the memory controller
mem_addr  out  ADDR_W  word address of the current request
mem_ack  in  1  request accepted this cycle
mem_rd_valid  in  1  read data returning, in issue order
mem_rd_data  in  DATA_W  returned word
SDRAM_FIFO  out  BURST_LEN x DATA_W  burst buffer; entry i = word (burst base + i)
DVAL  out  1  one-cycle pulse: buffer complete
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last burst of a layer
err_overflow  out  1  sticky; SRAM_read_req arrived while a request was already pending

Behaviour:
- Reset (async, rst=0): state IDLE. All outputs 0, buffer 0, counters 0, pending flag 0.
- States: IDLE, CFG, READY, FETCH, DELIVER.
- IDLE: Enable=1 -> CFG, beat counter := 0.
- CFG: on each busrdwr cycle, beat counter increments and the beat is handled as follows:
  - beat 1 -> weight_ptr;
  - beat 3 -> n_in;
  - beat 4 -> n_out;
  - beats 0 and 2 are ignored.
- After beat 4:
  - bursts_total := (n_in >> log2(BURST_LEN)) * n_out, computed in 32 bits;
  - if bursts_total = 0: done pulses the next cycle and the state returns to IDLE;
  - otherwise -> READY.
- Pending flag:
  - set by SRAM_read_req in any state except IDLE and CFG;
  - if already set when a new request arrives, the request is dropped and err_overflow is set;
  - err_overflow clears only on reset.
- READY: pending=1 -> FETCH next cycle; pending, issue_cnt and ret_cnt cleared.
- FETCH, issue side:
  - mem_rd_req=1 while issue_cnt < BURST_LEN;
  - mem_addr = weight_ptr + issue_cnt, modulo 2^ADDR_W;
  - issue_cnt advances only on mem_rd_req and mem_ack in the same cycle; address holds stable until acked.
- FETCH, return side:
  - on mem_rd_valid with ret_cnt < BURST_LEN, SDRAM_FIFO[ret_cnt] := mem_rd_data and ret_cnt increments;
  - extra returns are discarded.
- FETCH exit: ret_cnt reaches BURST_LEN -> DELIVER.
- DELIVER (one cycle):
  - DVAL=1;
  - weight_ptr += BURST_LEN (wraps);
  - burst count increments;
  - if it was the last burst -> done=1 next cycle, then IDLE; else -> READY.
- Buffer stability: SDRAM_FIFO holds its contents from DVAL until the first write of the next burst. It is never cleared between bursts.
- Latency: with mem_ack always high and a fixed L-cycle return delay, DVAL rises BURST_LEN+L+2 cycles after the SRAM_read_req pulse.
- Signals outside their states:
  - mem_rd_valid outside FETCH is ignored (covers returns still in flight after a reset);
  - SRAM_read_req in IDLE or CFG is ignored;
  - Enable outside IDLE is ignored.
- A simultaneous SRAM_read_req and DVAL cycle is legal: the request becomes pending and is served on the next READY.

Decomposition:
- Shared package accel_pkg:
  - state enum weight_fetch_state_t;
  - config beat index constants CFG_BEAT_WADDR=1, CFG_BEAT_NIN=3, CFG_BEAT_NOUT=4;
  - PE_COUNT=16, shared with the accelerator FSM.
- Sub-module burst_buffer: BURST_LEN x DATA_W register file with write index/enable and a parallel read-out bus. All control stays in the top module.

Test Plan:
- Config beats (0x0000, 0x0100, 0x0200, 32, 2), memory returns addr^0xA5A5, one-cycle latency, always ack -> 4 bursts; addresses 0x0100..0x013F in order; each DVAL shows 16 correct words; done pulses once; busy falls after done.
- Random mem_ack stalls and 1-5 cycle return latency -> mem_addr never changes while unacked; SDRAM_FIFO contents identical to the no-stall run.
- n_in=8 (below BURST_LEN) -> no mem_rd_req ever; done pulses one cycle after beat 4.
- Weight base 0xFFF8 with one burst -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007.
- Two SRAM_read_req pulses during FETCH -> second sets err_overflow; exactly one extra burst is served.
- Assert rst mid-FETCH while returns are still in flight -> all outputs 0 immediately; stale returns are ignored; a new Enable and config completes correctly.

Source files
------------

// File: rtl/accel_pkg.sv
// Definitions shared by the accelerator FSM and the weight fetch responder:
// responder states, configuration beat positions and the PE count.
package accel_pkg;

    localparam int PE_COUNT = 16;

    localparam logic [2:0] CFG_BEAT_WADDR = 3'd1;
    localparam logic [2:0] CFG_BEAT_NIN   = 3'd3;
    localparam logic [2:0] CFG_BEAT_NOUT  = 3'd4;

    typedef enum logic [2:0] {
        WF_IDLE    = 3'd0,
        WF_CFG     = 3'd1,
        WF_READY   = 3'd2,
        WF_FETCH   = 3'd3,
        WF_DELIVER = 3'd4
    } weight_fetch_state_t;

    // Bursts per layer: one burst covers PE_COUNT inputs of one output.
    function automatic logic [31:0] bursts_for_layer(input logic [15:0] n_in,
                                                     input logic [15:0] n_out,
                                                     input int          shift);
        return 32'(n_in >> shift) * 32'(n_out);
    endfunction

endpackage

// File: rtl/burst_buffer.sv
// Burst register file: one write port indexed by return order, with every
// entry visible in parallel on the read-out bus.
module burst_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(DEPTH)-1:0]      wr_idx,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DEPTH-1:0][DATA_W-1:0]  rd_data
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_r;

    // Entry storage; contents persist until overwritten by the next burst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r <= '0;
        end else if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_r;

endmodule

// File: rtl/weight_fetch_responder.sv
// Responder for the SRAM_read_req / DVAL weight handshake: captures the layer
// configuration, fetches one burst per request and presents it in parallel.
module weight_fetch_responder
    import accel_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int BURST_LEN = PE_COUNT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              Enable,
    input  logic [15:0]                       databus,
    input  logic                              busrdwr,
    input  logic                              SRAM_read_req,
    output logic                              mem_rd_req,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic                              mem_ack,
    input  logic                              mem_rd_valid,
    input  logic [DATA_W-1:0]                 mem_rd_data,
    output logic [BURST_LEN-1:0][DATA_W-1:0]  SDRAM_FIFO,
    output logic                              DVAL,
    output logic                              busy,
    output logic                              done,
    output logic                              err_overflow
);

    localparam int IDX_W = $clog2(BURST_LEN);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

    weight_fetch_state_t state_r;
    logic [2:0]          beat_cnt_r;
    logic [ADDR_W-1:0]   weight_ptr_r;
    logic [15:0]         n_in_r;
    logic [31:0]         bursts_total_r;
    logic [31:0]         burst_cnt_r;
    logic [CNT_W-1:0]    issue_cnt_r;
    logic [CNT_W-1:0]    ret_cnt_r;
    logic                pending_r;
    logic                err_overflow_r;
    logic                mem_rd_req_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                dval_r;
    logic                busy_r;
    logic                done_r;

    logic                issue_fire_s;
    logic                ret_fire_s;
    logic                req_accept_s;
    logic [CNT_W-1:0]    issue_next_s;
    logic [31:0]         bursts_cfg_s;

    assign issue_fire_s = mem_rd_req_r & mem_ack;
    assign issue_next_s = issue_cnt_r + CNT_W'(1);
    // Returns outside FETCH (e.g. in flight across a reset) never reach the buffer
    assign ret_fire_s   = (state_r == WF_FETCH) & mem_rd_valid & (ret_cnt_r < BURST_LEN_C);
    assign req_accept_s = SRAM_read_req &
                          ((state_r == WF_READY) | (state_r == WF_FETCH) | (state_r == WF_DELIVER));
    assign bursts_cfg_s = bursts_for_layer(n_in_r, databus, IDX_W);

    // Control FSM with request tracking and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= WF_IDLE;
            beat_cnt_r     <= 3'd0;
            weight_ptr_r   <= '0;
            n_in_r         <= 16'd0;
            bursts_total_r <= 32'd0;
            burst_cnt_r    <= 32'd0;
            issue_cnt_r    <= '0;
            ret_cnt_r      <= '0;
            pending_r      <= 1'b0;
            err_overflow_r <= 1'b0;
            mem_rd_req_r   <= 1'b0;
            mem_addr_r     <= '0;
            dval_r         <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            dval_r <= 1'b0;
            done_r <= 1'b0;

            if (req_accept_s) begin
                if (pending_r) begin
                    err_overflow_r <= 1'b1;
                end else begin
                    pending_r <= 1'b1;
                end
            end

            case (state_r)
                WF_IDLE: begin
                    if (Enable) begin
                        state_r    <= WF_CFG;
                        beat_cnt_r <= 3'd0;
                        busy_r     <= 1'b1;
                    end
                end

                WF_CFG: begin
                    if (busrdwr) begin
                        beat_cnt_r <= beat_cnt_r + 3'd1;
                        case (beat_cnt_r)
                            CFG_BEAT_WADDR: weight_ptr_r <= ADDR_W'(databus);
                            CFG_BEAT_NIN:   n_in_r       <= databus;
                            CFG_BEAT_NOUT: begin
                                bursts_total_r <= bursts_cfg_s;
                                burst_cnt_r    <= 32'd0;
                                if (bursts_cfg_s == 32'd0) begin
                                    state_r <= WF_IDLE;
                                    busy_r  <= 1'b0;
                                    done_r  <= 1'b1;
                                end else begin
                                    state_r <= WF_READY;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                WF_READY: begin
                    if (pending_r) begin
                        state_r      <= WF_FETCH;
                        pending_r    <= 1'b0;
                        issue_cnt_r  <= '0;
                        ret_cnt_r    <= '0;
                        mem_rd_req_r <= 1'b1;
                        mem_addr_r   <= weight_ptr_r;
                    end
                end

                WF_FETCH: begin
                    // Address only moves on an accepted request
                    if (issue_fire_s) begin
                        issue_cnt_r  <= issue_next_s;
                        mem_rd_req_r <= (issue_next_s < BURST_LEN_C);
                        mem_addr_r   <= weight_ptr_r + ADDR_W'(issue_next_s);
                    end
                    if (ret_fire_s) begin
                        ret_cnt_r <= ret_cnt_r + CNT_W'(1);
                        if (ret_cnt_r == BURST_LEN_C - CNT_W'(1)) begin
                            state_r      <= WF_DELIVER;
                            dval_r       <= 1'b1;
                            mem_rd_req_r <= 1'b0;
                        end
                    end
                end

                WF_DELIVER: begin
                    weight_ptr_r <= weight_ptr_r + ADDR_W'(BURST_LEN);
                    burst_cnt_r  <= burst_cnt_r + 32'd1;
                    if ((burst_cnt_r + 32'd1) == bursts_total_r) begin
                        state_r <= WF_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= WF_READY;
                    end
                end

                default: begin
                    state_r      <= WF_IDLE;
                    busy_r       <= 1'b0;
                    mem_rd_req_r <= 1'b0;
                end
            endcase
        end
    end

    burst_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (BURST_LEN)
    ) u_burst_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ret_fire_s),
        .wr_idx  (ret_cnt_r[IDX_W-1:0]),
        .wr_data (mem_rd_data),
        .rd_data (SDRAM_FIFO)
    );

    assign mem_rd_req   = mem_rd_req_r;
    assign mem_addr     = mem_addr_r;
    assign DVAL         = dval_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_overflow = err_overflow_r;

endmodule

// File: tb/tb_weight_fetch_responder.sv
// Directed bench for weight_fetch_responder with a reactive memory model that
// returns addr^0xA5A5 in issue order after a configurable latency.
module tb_weight_fetch_responder;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    Enable = 1'b0;
    logic [15:0]             databus = 16'd0;
    logic                    busrdwr = 1'b0;
    logic                    SRAM_read_req = 1'b0;
    logic                    mem_rd_req;
    logic [15:0]             mem_addr;
    logic                    mem_ack = 1'b1;
    logic                    mem_rd_valid = 1'b0;
    logic [15:0]             mem_rd_data = 16'd0;
    logic [15:0][15:0]       fifo_s;
    logic                    DVAL;
    logic                    busy;
    logic                    done;
    logic                    err_overflow;

    weight_fetch_responder #(.DATA_W(16), .ADDR_W(16), .BURST_LEN(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .Enable        (Enable),
        .databus       (databus),
        .busrdwr       (busrdwr),
        .SRAM_read_req (SRAM_read_req),
        .mem_rd_req    (mem_rd_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .SDRAM_FIFO    (fifo_s),
        .DVAL          (DVAL),
        .busy          (busy),
        .done          (done),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          due;
    } resp_t;

    resp_t       rq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          rand_mode = 0;
    int          lat_fix = 1;
    int          lat_v;
    int          due_v;
    int          dval_cnt = 0;
    int          dval_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          hs_cnt = 0;
    int          req_cycles = 0;
    int          beat4_cyc = 0;
    logic        have_prev = 1'b0;
    logic [15:0] prev_addr = 16'd0;
    logic [15:0] exp_issue = 16'd0;
    logic [15:0] exp_ptr = 16'd0;
    logic [15:0] a_v;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory return driver and acknowledge generator
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        mem_rd_valid = 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = rq[0].data;
            void'(rq.pop_front());
        end
        mem_ack = (rand_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Mid-cycle monitor: request capture, address checks, burst contents
    always @(negedge clk) begin
        if (rst) begin
            if (mem_rd_req) req_cycles++;
            if (have_prev && mem_rd_req) check_eq("addr_hold", {16'd0, mem_addr}, {16'd0, prev_addr});
            have_prev = mem_rd_req && !mem_ack;
            prev_addr = mem_addr;
            if (mem_rd_req && mem_ack) begin
                check_eq("issue_addr", {16'd0, mem_addr}, {16'd0, exp_issue});
                exp_issue = exp_issue + 16'd1;
                hs_cnt++;
                lat_v = (rand_mode != 0) ? $urandom_range(1, 5) : lat_fix;
                due_v = cyc + lat_v;
                if (due_v <= last_due) due_v = last_due + 1;
                last_due = due_v;
                rq.push_back('{data: mem_addr ^ 16'hA5A5, due: due_v});
            end
            if (DVAL) begin
                dval_cnt++;
                dval_cyc = cyc;
                for (int i = 0; i < 16; i++) begin
                    a_v = exp_ptr + 16'(i);
                    check_eq($sformatf("fifo[%0d]", i), {16'd0, fifo_s[i]}, {16'd0, a_v ^ 16'hA5A5});
                end
                exp_ptr = exp_ptr + 16'd16;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            have_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
    endtask

    task automatic cfg(input logic [15:0] w, input logic [15:0] nin, input logic [15:0] nout);
        logic [15:0] beats [5];
        beats = '{16'h0000, w, 16'h0200, nin, nout};
        exp_issue = w;
        exp_ptr   = w;
        Enable = 1'b1;
        step();
        Enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            busrdwr   = 1'b1;
            databus   = beats[i];
            beat4_cyc = cyc;
            step();
        end
        busrdwr = 1'b0;
    endtask

    task automatic pulse();
        SRAM_read_req = 1'b1;
        step();
        SRAM_read_req = 1'b0;
    endtask

    task automatic wait_dval(input int n0, input int budget);
        int t = 0;
        while (dval_cnt <= n0 && t < budget) begin
            step();
            t++;
        end
        check_eq("dval_wait", {31'd0, dval_cnt > n0}, 32'd1);
    endtask

    int n0, d0, h0, r0, rc;

    initial begin
        // Reset state
        repeat (2) step();
        check_eq("rst_req",  {31'd0, mem_rd_req}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_dval", {31'd0, DVAL}, 32'd0);
        check_eq("rst_fifo", {31'd0, |fifo_s}, 32'd0);
        rst = 1'b1;
        step();

        // Nominal layer: 4 bursts, latency 1, always ack
        rand_mode = 0; lat_fix = 1;
        d0 = done_cnt; h0 = hs_cnt;
        cfg(16'h0100, 16'd32, 16'd2);
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        for (int b = 0; b < 4; b++) begin
            n0 = dval_cnt;
            rc = cyc;
            pulse();
            wait_dval(n0, 200);
            if (b == 0) check_eq("t1_latency", dval_cyc - rc, 32'd19);
        end
        repeat (3) step();
        check_eq("t1_done_cnt", done_cnt - d0, 32'd1);
        check_eq("t1_done_cyc", done_cyc, dval_cyc + 1);
        check_eq("t1_busy_end", {31'd0, busy}, 32'd0);
        check_eq("t1_issues", hs_cnt - h0, 32'd64);
        check_eq("t1_ptr_end", {16'd0, exp_issue}, 32'h0140);

        // Random ack stalls and 1..5 cycle latency
        rand_mode = 1;
        d0 = done_cnt; h0 = hs_cnt;
        cfg(16'h0100, 16'd32, 16'd2);
        for (int b = 0; b < 4; b++) begin
            n0 = dval_cnt;
            pulse();
            wait_dval(n0, 400);
        end
        repeat (3) step();
        check_eq("t2_done_cnt", done_cnt - d0, 32'd1);
        check_eq("t2_issues", hs_cnt - h0, 32'd64);
        rand_mode = 0;
        repeat (8) step();

        // n_in below burst length: no fetch, immediate done
        d0 = done_cnt; r0 = req_cycles;
        cfg(16'h0000, 16'd8, 16'd4);
        step();
        check_eq("t3_done_cnt", done_cnt - d0, 32'd1);
        check_eq("t3_done_cyc", done_cyc, beat4_cyc + 1);
        check_eq("t3_busy", {31'd0, busy}, 32'd0);
        pulse();
        step();
        check_eq("t3_idle_req", {31'd0, busy}, 32'd0);
        check_eq("t3_no_req", req_cycles - r0, 32'd0);
        check_eq("t3_no_ovf", {31'd0, err_overflow}, 32'd0);

        // Address wrap at top of memory
        d0 = done_cnt; h0 = hs_cnt;
        cfg(16'hFFF8, 16'd16, 16'd1);
        n0 = dval_cnt;
        pulse();
        wait_dval(n0, 200);
        repeat (3) step();
        check_eq("t4_done_cnt", done_cnt - d0, 32'd1);
        check_eq("t4_wrap_end", {16'd0, exp_issue}, 32'h0008);

        // Overflow: two requests during FETCH, one extra burst served
        d0 = done_cnt;
        cfg(16'h0200, 16'd32, 16'd2);
        n0 = dval_cnt;
        pulse();
        repeat (3) step();
        pulse();
        check_eq("t5_ovf0", {31'd0, err_overflow}, 32'd0);
        pulse();
        check_eq("t5_ovf1", {31'd0, err_overflow}, 32'd1);
        wait_dval(n0, 200);
        wait_dval(n0 + 1, 200);
        repeat (60) step();
        check_eq("t5_bursts", dval_cnt - n0, 32'd2);
        check_eq("t5_busy", {31'd0, busy}, 32'd1);
        check_eq("t5_sticky", {31'd0, err_overflow}, 32'd1);
        check_eq("t5_no_done", done_cnt - d0, 32'd0);

        // Reset mid-FETCH with returns in flight
        do_reset();
        lat_fix = 5;
        cfg(16'h0300, 16'd32, 16'd2);
        pulse();
        repeat (8) step();
        rst = 1'b0;
        #1;
        check_eq("t6_req",  {31'd0, mem_rd_req}, 32'd0);
        check_eq("t6_addr", {16'd0, mem_addr}, 32'd0);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_dval", {31'd0, DVAL}, 32'd0);
        check_eq("t6_fifo", {31'd0, |fifo_s}, 32'd0);
        repeat (2) step();
        rst = 1'b1;
        d0 = done_cnt;
        cfg(16'h0400, 16'd16, 16'd1);
        check_eq("t6_stale", {31'd0, |fifo_s}, 32'd0);
        n0 = dval_cnt;
        pulse();
        wait_dval(n0, 200);
        repeat (3) step();
        check_eq("t6_done_cnt", done_cnt - d0, 32'd1);
        check_eq("t6_busy_end", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
